// File: rtl/priority_decoder_38_pkg.sv
// Shared constants, FSM state type and code-to-select helper for priority_decoder_38.
package priority_decoder_38_pkg;
  localparam int CODE_W = 3;
  localparam int Y_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_e;

  function automatic logic [Y_W-1:0] onehot(input logic [CODE_W-1:0] c);
    logic [Y_W-1:0] r;
    r    = '0;
    r[c] = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/priority_decoder_38_fifo.sv
// Synchronous FIFO buffering incoming codes; power-of-two depth so pointers wrap naturally.
module priority_decoder_38_fifo
  import priority_decoder_38_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = CODE_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  logic [WIDTH-1:0]              wdata_i,
  input  logic                          pop_i,
  output logic [WIDTH-1:0]              rdata_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    // A simultaneous push and pop leaves occupancy unchanged.
    if (do_push && !do_pop)      level_d = level_q + 1'b1;
    else if (do_pop && !do_push) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/priority_decoder_38.sv
// Buffered 3-to-8 decoder replaying codes as timed one-hot strobes with a one-cycle gap.
// Define PRIORITY_DECODER_38_CODE0_NULL_EN to discard code 0 as "no line asserted".
module priority_decoder_38
  import priority_decoder_38_pkg::*;
#(
  parameter int PULSE_W    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CODE_W-1:0]            code,
  input  logic                         code_valid,
  output logic                         code_ready,
  output logic [Y_W-1:0]               y,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  level
);
  localparam int CNT_W = $clog2(PULSE_W + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic              full, empty, pop, null_code;
  logic [CODE_W-1:0] head;

  assign code_ready = !rst && !full;

  priority_decoder_38_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (CODE_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (code_valid && code_ready),
    .wdata_i (code),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

`ifdef PRIORITY_DECODER_38_CODE0_NULL_EN
  assign null_code = (head == '0);
`else
  assign null_code = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE, GAP: begin
        y_d     = '0;
        state_d = IDLE;
        // A null code is consumed without a strobe or a trailing gap.
        if (!empty) begin
          pop = 1'b1;
          if (!null_code) begin
            y_d     = onehot(head);
            cnt_d   = CNT_W'(PULSE_W - 1);
            state_d = PULSE;
          end
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          y_d     = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        y_d     = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end

  assign y    = y_q;
  assign busy = (state_q != IDLE) || !empty;
endmodule

// File: tb/tb_priority_decoder_38.sv
// Self-checking bench for priority_decoder_38: directed tables plus randomized traffic vs a slot-schedule model.
module tb_priority_decoder_38;
  localparam int PULSE_W    = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       code;
  logic             code_valid;
  logic             code_ready;
  logic [7:0]       y;
  logic             busy;
  logic [LVL_W-1:0] level;

  priority_decoder_38 #(.PULSE_W(PULSE_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .y          (y),
    .busy       (busy),
    .level      (level)
  );

  always #5 clk = ~clk;

`ifdef PRIORITY_DECODER_38_CODE0_NULL_EN
  localparam bit NULL0 = 1'b1;
`else
  localparam bit NULL0 = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: a queue of accepted codes and the edge numbers at which
  // the decoder's current strobe ends and at which it may next take a code.
  int         q[$];
  int         edge_n      = 0;
  int         next_pop_ok = 0;
  int         pulse_end   = 0;
  int         busy_until  = -1;
  logic [7:0] cur_y       = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  task automatic model_edge();
    int sz;
    bit acc;
    int c;
    sz = q.size();
    edge_n++;
    if (rst) begin
      q.delete();
      pulse_end   = 0;
      busy_until  = -1;
      next_pop_ok = 0;
    end else begin
      acc = code_valid && (sz < FIFO_DEPTH);
      if (sz > 0 && edge_n >= next_pop_ok) begin
        c = q.pop_front();
        if (NULL0 && c == 0) begin
          next_pop_ok = edge_n + 1;
        end else begin
          cur_y       = 8'(1 << c);
          pulse_end   = edge_n + PULSE_W;
          busy_until  = edge_n + PULSE_W;
          next_pop_ok = edge_n + PULSE_W + 1;
        end
      end
      if (acc) q.push_back(int'(code));
    end
  endtask

  task automatic model_check();
    check("y",          32'(y),          32'((edge_n < pulse_end) ? cur_y : 8'h00));
    check("level",      32'(level),      32'(q.size()));
    check("busy",       32'(busy),       32'((q.size() > 0) || (edge_n <= busy_until)));
    check("code_ready", 32'(code_ready), 32'(!rst && (q.size() < FIFO_DEPTH)));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    model_check();
  endtask

  task automatic idle(input int n);
    code_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {
    logic [2:0] code;
    logic [7:0] exp_y;
  } vec_t;

  vec_t       tbl[8];
  logic [7:0] ylog[16];
  int         lv[16];
  bit         saw_full, saw_dip;
  logic [7:0] burst_exp[9];
  logic [7:0] z_exp[6];
  int         z_len;

  initial begin
    tbl[0] = '{3'd0, NULL0 ? 8'h00 : 8'h01};
    tbl[1] = '{3'd1, 8'h02};
    tbl[2] = '{3'd2, 8'h04};
    tbl[3] = '{3'd3, 8'h08};
    tbl[4] = '{3'd4, 8'h10};
    tbl[5] = '{3'd5, 8'h20};
    tbl[6] = '{3'd6, 8'h40};
    tbl[7] = '{3'd7, 8'h80};
    burst_exp = '{8'h80, 8'h80, 8'h00, 8'h08, 8'h08, 8'h00, 8'h02, 8'h02, 8'h00};
    if (NULL0) begin
      z_exp = '{8'h00, 8'h04, 8'h04, 8'h00, 8'h00, 8'h00};
      z_len = 4;
    end else begin
      z_exp = '{8'h01, 8'h01, 8'h00, 8'h04, 8'h04, 8'h00};
      z_len = 6;
    end

    // Reset with valid held high.
    rst = 1'b1; code_valid = 1'b1; code = 3'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_y", 32'(y), 32'h0);
      check("rst_ready", 32'(code_ready), 32'h0);
      check("rst_level", 32'(level), 32'h0);
    end
    rst = 1'b0; code_valid = 1'b0;
    #1;
    check("ready_after_rst", 32'(code_ready), 32'h1);

    // One code at a time from the table.
    for (int i = 0; i < 8; i++) begin
      code_valid = 1'b1; code = tbl[i].code;
      step();                 // t0: accept
      code_valid = 1'b0;
      step(); check("tbl_y_t1", 32'(y), 32'(tbl[i].exp_y));
      step(); check("tbl_y_t2", 32'(y), 32'(tbl[i].exp_y));
      step(); check("tbl_y_t3", 32'(y), 32'h0);
      step(); check("tbl_busy_t4", 32'(busy), 32'h0);
    end

    // Burst 7,3,1.
    code_valid = 1'b1; code = 3'd7; step();
    code = 3'd3; step(); ylog[0] = y;
    code = 3'd1; step(); ylog[1] = y;
    code_valid = 1'b0;
    for (int i = 2; i < 9; i++) begin step(); ylog[i] = y; end
    for (int i = 0; i < 9; i++) check("burst_y", 32'(ylog[i]), 32'(burst_exp[i]));
    idle(3);

    // Fill the FIFO and keep offering codes: watch full stall and refill after pops.
    saw_full = 1'b0; saw_dip = 1'b0;
    code_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      code = 3'($urandom_range(1, 7));
      step();
      lv[i] = int'(level);
      if (level == LVL_W'(FIFO_DEPTH) && !code_ready) saw_full = 1'b1;
    end
    for (int i = 0; i + 2 < 14; i++)
      if (lv[i] == FIFO_DEPTH && lv[i+1] == FIFO_DEPTH - 1 && lv[i+2] == FIFO_DEPTH) saw_dip = 1'b1;
    check("full_stall", 32'(saw_full), 32'h1);
    check("full_dip_refill", 32'(saw_dip), 32'h1);
    idle(20);

    // Reset mid-pulse with two codes queued.
    code_valid = 1'b1; code = 3'd4; step();
    code = 3'd2; step();
    code = 3'd6; step();
    code_valid = 1'b0;
    check("pre_rst_y", 32'(y), 32'h10);
    check("pre_rst_level", 32'(level), 32'h2);
    rst = 1'b1; step();
    check("midrst_y", 32'(y), 32'h0);
    check("midrst_level", 32'(level), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin step(); check("post_rst_quiet", 32'(y), 32'h0); end

    // Code 0 followed by code 2.
    code_valid = 1'b1; code = 3'd0; step();
    code = 3'd2; step(); ylog[0] = y;
    code_valid = 1'b0;
    for (int i = 1; i < 6; i++) begin step(); ylog[i] = y; end
    for (int i = 0; i < z_len; i++) check("zero_then_two", 32'(ylog[i]), 32'(z_exp[i]));
    idle(6);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 59) == 0);
      code_valid = ($urandom_range(0, 9) < 6);
      code       = 3'($urandom_range(0, 7));
      step();
      check("y_onehot", 32'($countones(y) <= 1), 32'h1);
    end
    rst = 1'b0;
    idle(25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
